// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC write sequencer: FSM states, mode codes,
// and the BCD register address map indexed by load-mux select.
package rtc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    LATCH = 3'd2,
    REQ   = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [1:0] MODE_ALL     = 2'b00;
  localparam logic [1:0] MODE_TIME    = 2'b01;
  localparam logic [1:0] MODE_TIMER   = 2'b10;
  localparam logic [1:0] MODE_ALL_ALT = 2'b11;

  localparam int N_ADDR = 9;

  // Index = sel_LD value; entries 0..5 are time/date, 6..8 are the timer.
  localparam logic [7:0] ADDR_TABLE [N_ADDR] = '{
    8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
    8'h41, 8'h42, 8'h43
  };

  localparam logic [3:0] SEL_FIRST       = 4'd0;
  localparam logic [3:0] SEL_TIME_LAST   = 4'd5;
  localparam logic [3:0] SEL_TIMER_FIRST = 4'd6;
  localparam logic [3:0] SEL_TIMER_LAST  = 4'd8;
  localparam logic [3:0] SEL_ALL_LAST    = 4'd8;

  function automatic logic [3:0] first_idx(input logic [1:0] m);
    return (m == MODE_TIMER) ? SEL_TIMER_FIRST : SEL_FIRST;
  endfunction

  function automatic logic [3:0] last_idx(input logic [1:0] m);
    case (m)
      MODE_TIME:  return SEL_TIME_LAST;
      MODE_TIMER: return SEL_TIMER_LAST;
      default:    return SEL_ALL_LAST;
    endcase
  endfunction

endpackage

// File: rtl/rtc_addr_lut.sv
// Purpose: maps a load-mux select index to its RTC register address.
// Latency: combinational. Backpressure: none; out-of-range indices give 0x00.
module rtc_addr_lut
  import rtc_pkg::*;
(
  input  logic [3:0] idx,
  output logic [7:0] addr
);

  always_comb begin
    addr = 8'h00;
    if (idx < 4'(N_ADDR)) begin
      addr = ADDR_TABLE[idx];
    end
  end

endmodule

// File: rtl/rtc_write_sequencer.sv
// Purpose: steps sel_LD over the selected RTC registers and issues one write each.
// Latency: start@t -> sel_LD@t+1, wr_req@t+3. Backpressure: wr_req held until wr_done;
// RTC_WRITE_TIMEOUT_EN adds a per-write timeout and a sticky error output.
module rtc_write_sequencer
  import rtc_pkg::*;
#(
  parameter int N_REG = 9,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [7:0] ld_bcd,
  input  logic       wr_done,
  output logic [3:0] sel_LD,
  output logic       wr_req,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       done
`ifdef RTC_WRITE_TIMEOUT_EN
  ,
  output logic       error
`endif
);

  state_t     state, state_nxt;
  logic [3:0] idx, idx_nxt;
  logic [3:0] last, last_nxt;
  logic [3:0] sel_nxt;
  logic       req_nxt;
  logic [7:0] addr_nxt, data_nxt;
  logic [7:0] lut_addr;

`ifdef RTC_WRITE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err_nxt;
`endif

  rtc_addr_lut u_addr_lut (
    .idx  (idx),
    .addr (lut_addr)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    last_nxt  = last;
    sel_nxt   = sel_LD;
    req_nxt   = wr_req;
    addr_nxt  = wr_addr;
    data_nxt  = wr_data;
`ifdef RTC_WRITE_TIMEOUT_EN
    err_nxt   = error;
    // Counts only while the request is visible on the bus; any other state clears it.
    cnt_nxt   = (state == REQ && wr_req) ? cnt + 1'b1 : '0;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          idx_nxt   = first_idx(mode);
          last_nxt  = last_idx(mode);
          state_nxt = SEL;
`ifdef RTC_WRITE_TIMEOUT_EN
          err_nxt   = 1'b0;
`endif
        end
      end
      SEL: begin
        sel_nxt   = idx;
        addr_nxt  = lut_addr;
        state_nxt = LATCH;
      end
      LATCH: begin
        // sel_LD has been stable for a full cycle, so the mux output is settled.
        data_nxt  = ld_bcd;
        state_nxt = REQ;
      end
      REQ: begin
        // wr_done only counts once the request is actually on the bus.
        if (!wr_req) begin
          req_nxt = 1'b1;
        end else if (wr_done) begin
          req_nxt   = 1'b0;
          state_nxt = NEXT;
        end
`ifdef RTC_WRITE_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          req_nxt   = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end
`endif
      end
      NEXT: begin
        if (idx == last || idx >= 4'(N_REG - 1)) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + 4'd1;
          state_nxt = SEL;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= 4'd0;
      last    <= 4'd0;
      sel_LD  <= 4'd0;
      wr_req  <= 1'b0;
      wr_addr <= 8'h00;
      wr_data <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef RTC_WRITE_TIMEOUT_EN
      cnt     <= '0;
      error   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      last    <= last_nxt;
      sel_LD  <= sel_nxt;
      wr_req  <= req_nxt;
      wr_addr <= addr_nxt;
      wr_data <= data_nxt;
      busy    <= (state_nxt != IDLE);
      done    <= (state_nxt == DONE);
`ifdef RTC_WRITE_TIMEOUT_EN
      cnt     <= cnt_nxt;
      error   <= err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Bench for rtc_write_sequencer: a modelled load mux and RTC bus interface, with a
// scoreboard of expected writes checked by an independent monitor.
module tb_rtc_write_sequencer;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic [3:0] sel;
    logic [7:0] hold;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic [7:0] ld_bcd;
  logic       wr_done;
  logic [3:0] sel_LD;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
`ifdef RTC_WRITE_TIMEOUT_EN
  logic       error;
`endif

  int n_pass = 0;
  int n_total = 0;

  exp_t exp_q[$];
  logic [7:0] addr_tab [9];
  logic [7:0] mux_regs [16];

  int  bus_delay = 2;
  int  slow_at = -1;
  int  slow_delay = 50;
  int  bus_writes = 0;
  bit  bus_en = 1'b1;
  logic bus_done;
  logic stray;

  int req_rises = 0;
  int done_seen = 0;
  int done_exp = 0;

  rtc_write_sequencer #(.N_REG(9), .TIMEOUT_CYCLES(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mode    (mode),
    .ld_bcd  (ld_bcd),
    .wr_done (wr_done),
    .sel_LD  (sel_LD),
    .wr_req  (wr_req),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done)
`ifdef RTC_WRITE_TIMEOUT_EN
    ,
    .error   (error)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Load mux: seg, min, hora, dia, mes, anio, seg_t, min_t, hora_t.
  initial begin
    addr_tab = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    for (int i = 0; i < 16; i++) mux_regs[i] = 8'hEE;
    mux_regs[0] = 8'h59; mux_regs[1] = 8'h47; mux_regs[2] = 8'h23;
    mux_regs[3] = 8'h15; mux_regs[4] = 8'h08; mux_regs[5] = 8'h24;
    mux_regs[6] = 8'h30; mux_regs[7] = 8'h05; mux_regs[8] = 8'h12;
  end
  assign ld_bcd  = mux_regs[sel_LD];
  assign wr_done = bus_done | stray;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_total++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, expv, $time);
  endtask

  // RTC bus interface model: completes each request a set number of cycles after it rises.
  initial begin
    int cnt;
    cnt = 0;
    bus_done = 1'b0;
    forever begin
      @(negedge clk);
      bus_done = 1'b0;
      if (wr_req && bus_en) begin
        cnt++;
        if (cnt == ((bus_writes == slow_at) ? slow_delay : bus_delay)) begin
          bus_done = 1'b1;
          cnt = 0;
          bus_writes++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: pops on each new request, tracks stability and hold length, counts done pulses.
  initial begin
    exp_t cur;
    logic req_q, done_q, unstable;
    logic [7:0] cap_addr, cap_data;
    logic [3:0] cap_sel;
    int hold_cnt, done_w;
    req_q = 1'b0; done_q = 1'b0; unstable = 1'b0; hold_cnt = 0; done_w = 0;
    cur = '0; cap_addr = '0; cap_data = '0; cap_sel = '0;
    forever begin
      @(negedge clk);
      if (wr_req === 1'b1 && !req_q) begin
        req_rises++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL extra_write: addr 0x%0h data 0x%0h, no write expected", wr_addr, wr_data);
          cur = '0;
        end else begin
          cur = exp_q.pop_front();
          check("wr_addr", wr_addr, cur.addr);
          check("wr_data", wr_data, cur.data);
          check("sel_LD", sel_LD, cur.sel);
        end
        cap_addr = wr_addr; cap_data = wr_data; cap_sel = sel_LD;
        unstable = 1'b0;
        hold_cnt = 1;
      end else if (wr_req === 1'b1 && req_q) begin
        hold_cnt++;
        if (wr_addr !== cap_addr || wr_data !== cap_data || sel_LD !== cap_sel) unstable = 1'b1;
      end else if (req_q) begin
        check("req_stable", unstable, 1'b0);
        if (cur.hold != 0) check("req_hold_cycles", hold_cnt, cur.hold);
      end
      req_q = (wr_req === 1'b1);

      if (done === 1'b1) begin
        done_seen++;
        done_w++;
      end else if (done_q) begin
        check("done_width", done_w, 1);
        done_w = 0;
      end
      done_q = (done === 1'b1);
    end
  end

  task automatic push(input int i, input int hold);
    exp_t e;
    e.addr = addr_tab[i];
    e.data = mux_regs[i];
    e.sel  = 4'(i);
    e.hold = 8'(hold);
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [1:0] m);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_seq(input int budget);
    int n;
    done_exp++;
    n = 0;
    while (done_seen < done_exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_count", done_seen, done_exp);
    @(negedge clk);
    check("busy_after_done", busy, 1'b0);
    check("writes_pending", exp_q.size(), 0);
  endtask

  initial begin
    int base, n, done_base;
    reset = 1'b1; start = 1'b0; mode = 2'b00; stray = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sel_LD", sel_LD, 4'd0);
    check("rst_wr_req", wr_req, 1'b0);
    check("rst_wr_addr", wr_addr, 8'h00);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
`ifdef RTC_WRITE_TIMEOUT_EN
    check("rst_error", error, 1'b0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // All registers, 2-cycle bus.
    for (int i = 0; i <= 8; i++) push(i, 2);
    do_start(2'b00);
    wait_seq(400);

    // Timer only, with start-to-output latency.
    for (int i = 6; i <= 8; i++) push(i, 2);
    do_start(2'b10);
    check("busy_after_start", busy, 1'b1);
    @(negedge clk);
    check("lat_sel_LD_t1", sel_LD, 4'd6);
    @(negedge clk);
    check("lat_wr_req_t2", wr_req, 1'b0);
    @(negedge clk);
    check("lat_wr_req_t3", wr_req, 1'b1);
    wait_seq(200);

    // Time/date only, third write stalls 50 cycles.
    slow_at = bus_writes + 2;
    for (int i = 0; i <= 5; i++) push(i, (i == 2) ? 50 : 2);
    do_start(2'b01);
    wait_seq(600);
    slow_at = -1;

    // Mode 11, extra start while busy and stray wr_done in SEL.
    for (int i = 0; i <= 8; i++) push(i, 2);
    base = req_rises;
    do_start(2'b11);
    n = 0;
    while (req_rises < base + 2 && n < 200) begin @(negedge clk); n++; end
    check("second_req_seen", (req_rises >= base + 2), 1'b1);
    do_start(2'b10);
    n = 0;
    while (wr_req && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    wait_seq(400);

    // Reset while the fourth write is outstanding.
    bus_delay = 10;
    for (int i = 0; i <= 3; i++) push(i, (i == 3) ? 0 : 10);
    base = req_rises;
    done_base = done_seen;
    do_start(2'b00);
    n = 0;
    while (req_rises < base + 4 && n < 400) begin @(negedge clk); n++; end
    check("fourth_req_seen", req_rises - base, 4);
    reset = 1'b1;
    @(negedge clk);
    check("abort_wr_req", wr_req, 1'b0);
    check("abort_sel_LD", sel_LD, 4'd0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_done", done_seen, done_base);
    check("abort_queue", exp_q.size(), 0);
    bus_delay = 2;
    for (int i = 0; i <= 8; i++) push(i, 2);
    do_start(2'b00);
    wait_seq(400);

`ifdef RTC_WRITE_TIMEOUT_EN
    // No completion ever: one write times out after 16 request cycles.
    bus_en = 1'b0;
    push(0, 16);
    do_start(2'b00);
    wait_seq(200);
    check("timeout_error_set", error, 1'b1);
    bus_en = 1'b1;
    for (int i = 6; i <= 8; i++) push(i, 2);
    do_start(2'b10);
    check("error_cleared_on_start", error, 1'b0);
    wait_seq(200);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
